// File: rtl/serial_priority_encoder_8_to_3.sv
// serial_priority_encoder_8_to_3
//
// Sequential 8-to-3 encoder. It captures an 8-bit request vector on load and
// presents the 3-bit index of each set bit, one per valid/ready handshake,
// in priority order. Once the last index has been accepted it reports that
// the vector is exhausted.
//
// Parameters
//   LSB_FIRST  0: d[7] has highest priority; 1: d[0] has highest priority
//
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous reset, active-high
//   d      in   8  request vector, sampled only when a load is accepted
//   load   in   1  capture d (accepted only in IDLE)
//   ready  in   1  consumer accepts a in this cycle
//   a      out  3  index of the current highest-priority pending bit
//   valid  out  1  a is meaningful
//   busy   out  1  vector in progress; load is ignored
//   done   out  1  1-cycle pulse after the last index is accepted
//   zero   out  1  1-cycle pulse when a load captured d == 8'h00
//
// All outputs come straight from flops. There is no combinational path from
// d, load or ready to any output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no vector pending; a load of a nonzero d starts a scan
// SCAN  | pend holds the bits not yet emitted; a is valid

module serial_priority_encoder_8_to_3 #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       load,
  input  logic       ready,
  output logic [2:0] a,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       zero
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state;
  logic [7:0] pend;
  logic [7:0] pend_clr;

  // Returns the winning index of v. The loop runs toward the highest-priority
  // bit, so the last set bit it sees is the one that wins.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--)
        if (v[i]) idx = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++)
        if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // a always mirrors pick(pend) while in SCAN. Clearing bit a therefore
  // retires exactly the index that is being handed over.
  assign pend_clr = pend & ~(8'b1 << a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 8'h00;
      a     <= 3'd0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      zero <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (d != 8'h00) begin
              pend  <= d;
              state <= SCAN;
              a     <= pick(d);
              valid <= 1'b1;
              busy  <= 1'b1;
            end else begin
              zero <= 1'b1;
            end
          end
        end
        SCAN: begin
          // load is deliberately ignored here, including on the final edge.
          if (valid && ready) begin
            pend <= pend_clr;
            if (pend_clr == 8'h00) begin
              state <= IDLE;
              a     <= 3'd0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              a <= pick(pend_clr);
            end
          end
        end
        default: begin
          state <= IDLE;
          pend  <= 8'h00;
          a     <= 3'd0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_priority_encoder_8_to_3.sv
module tb_serial_priority_encoder_8_to_3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       load;
  logic       ready;

  logic [2:0] a0, a1;
  logic       valid0, valid1, busy0, busy1, done0, done1, zero0, zero1;

  int tests = 0;
  int fails = 0;

  serial_priority_encoder_8_to_3 #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .d(d), .load(load), .ready(ready),
    .a(a0), .valid(valid0), .busy(busy0), .done(done0), .zero(zero0)
  );

  serial_priority_encoder_8_to_3 #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .d(d), .load(load), .ready(ready),
    .a(a1), .valid(valid1), .busy(busy1), .done(done1), .zero(zero1)
  );

  always #5 clk = ~clk;

  // Reference model. Each instance has a queue of the indices it still has to
  // emit, listed in emission order. Pulses are modelled as separate flags.
  int q0[$];
  int q1[$];
  bit m_done, m_zero;
  int log0[$];

  typedef struct {
    logic       load;
    logic [7:0] d;
    logic       ready;
    int         a0;
    int         a1;
    logic       valid;
    logic       done;
    logic       zero;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic l, input logic [7:0] dv, input logic r);
    m_done = 0;
    m_zero = 0;
    if (q0.size() != 0) begin
      if (r) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (q0.size() == 0) m_done = 1;
      end
    end else if (l) begin
      if (dv == 8'h00) m_zero = 1;
      else begin
        for (int i = 7; i >= 0; i--) if (dv[i]) q0.push_back(i);
        for (int i = 0; i < 8; i++)  if (dv[i]) q1.push_back(i);
      end
    end
  endtask

  task automatic check_model();
    int ea0, ea1;
    bit ev;
    ev  = (q0.size() != 0);
    ea0 = ev ? q0[0] : 0;
    ea1 = ev ? q1[0] : 0;
    chk("msb_a", a0, ea0);
    chk("msb_valid", valid0, ev);
    chk("msb_busy", busy0, ev);
    chk("msb_done", done0, m_done);
    chk("msb_zero", zero0, m_zero);
    chk("lsb_a", a1, ea1);
    chk("lsb_valid", valid1, ev);
    chk("lsb_busy", busy1, ev);
    chk("lsb_done", done1, m_done);
    chk("lsb_zero", zero1, m_zero);
  endtask

  task automatic step(input logic l, input logic [7:0] dv, input logic r);
    load  = l;
    d     = dv;
    ready = r;
    if (valid0 && r) log0.push_back(a0);
    @(posedge clk);
    model_edge(l, dv, r);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 0; d = 8'h00; ready = 0;
    q0.delete(); q1.delete();
    m_done = 0; m_zero = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-derived sequence for both priority orders, applied from reset.
    vecs[0]  = '{1, 8'hA5, 1, 7, 0, 1, 0, 0};
    vecs[1]  = '{0, 8'h00, 1, 5, 2, 1, 0, 0};
    vecs[2]  = '{0, 8'h00, 1, 2, 5, 1, 0, 0};
    vecs[3]  = '{0, 8'h00, 1, 0, 7, 1, 0, 0};
    vecs[4]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0};
    vecs[5]  = '{1, 8'h00, 1, 0, 0, 0, 0, 1};
    vecs[6]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 8'h10, 0, 4, 4, 1, 0, 0};
    vecs[8]  = '{1, 8'hFF, 0, 4, 4, 1, 0, 0};
    vecs[9]  = '{1, 8'hFF, 1, 0, 0, 0, 1, 0};
    vecs[10] = '{0, 8'h00, 0, 0, 0, 0, 0, 0};

    do_reset();
    #1;
    check_model();
    chk("reset_a", a0, 0);
    chk("reset_valid", valid0, 0);

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].load, vecs[i].d, vecs[i].ready);
      chk($sformatf("vec%0d_a_msb", i), a0, vecs[i].a0);
      chk($sformatf("vec%0d_a_lsb", i), a1, vecs[i].a1);
      chk($sformatf("vec%0d_valid", i), valid0, vecs[i].valid);
      chk($sformatf("vec%0d_busy", i), busy0, vecs[i].valid);
      chk($sformatf("vec%0d_done", i), done0, vecs[i].done);
      chk($sformatf("vec%0d_zero", i), zero0, vecs[i].zero);
    end

    // 8'hFF with ready alternating. Every index 7..0 must be accepted exactly once.
    log0.delete();
    step(1, 8'hFF, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, (i % 2) == 1);
    chk("ff_count", log0.size(), 8);
    for (int i = 0; i < 8 && i < log0.size(); i++)
      chk($sformatf("ff_order%0d", i), log0[i], 7 - i);

    // Reload in the done cycle: a=4 shows up on the cycle after that load.
    step(1, 8'h03, 1);
    step(1, 8'h77, 1);
    step(0, 8'h00, 1);
    chk("reload_done", done0, 1);
    step(1, 8'h10, 1);
    chk("reload_a", a0, 4);
    chk("reload_valid", valid0, 1);
    step(0, 8'h00, 1);

    // An asynchronous reset in the middle of a scan clears the outputs at once.
    step(1, 8'hF0, 0);
    step(0, 8'h00, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", valid0, 0);
    chk("rst_async_busy", busy0, 0);
    chk("rst_async_a", a0, 0);
    chk("rst_async_valid_lsb", valid1, 0);
    q0.delete(); q1.delete(); m_done = 0; m_zero = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

    // Random traffic, checked against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 3) == 0, rd, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
